// File: rtl/ex_branch_redirect_pkg.sv
// Shared definitions for the EX-stage branch resolver: branch type codes,
// branch condition encodings, FSM states and the default datapath width.
package ex_branch_redirect_pkg;

   localparam int unsigned XLEN_DEF = 32;

   typedef enum logic [1:0] {
      BR_NONE = 2'b00,
      BR_COND = 2'b01,
      BR_JAL  = 2'b10,
      BR_JALR = 2'b11
   } br_type_e;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_SHADOW = 1'b1
   } state_e;

endpackage

// File: rtl/ex_branch_redirect_if.sv
// ID/EX-to-EX/MEM bundle: decoded operands in, redirect and EX/MEM control out.
// master = upstream pipeline side, slave = the EX resolver.
interface ex_branch_redirect_if #(
   parameter int unsigned XLEN = 32
);
   logic            Stall;
   logic            InValid;
   logic [XLEN-1:0] InPC;
   logic [XLEN-1:0] rs1_value;
   logic [XLEN-1:0] rs2_value;
   logic [XLEN-1:0] Imm;
   logic [1:0]      BrType;
   logic [2:0]      Funct3;
   logic            InRegWrite;

   logic            PCsel;
   logic [XLEN-1:0] JumporBranch;
   logic            Flush;
   logic            ExValid;
   logic            ExRegWrite;
   logic [XLEN-1:0] ExLink;
   logic            MisalignErr;
   logic            IllegalBr;

   modport master (
      output Stall, InValid, InPC, rs1_value, rs2_value, Imm, BrType, Funct3, InRegWrite,
      input  PCsel, JumporBranch, Flush, ExValid, ExRegWrite, ExLink, MisalignErr, IllegalBr
   );

   modport slave (
      input  Stall, InValid, InPC, rs1_value, rs2_value, Imm, BrType, Funct3, InRegWrite,
      output PCsel, JumporBranch, Flush, ExValid, ExRegWrite, ExLink, MisalignErr, IllegalBr
   );
endinterface

// File: rtl/ex_branch_redirect_branch_compare.sv
// Combinational branch condition evaluator: (a, b, funct3) -> {take, illegal}.
module branch_compare
   import ex_branch_redirect_pkg::*;
#(
   parameter int unsigned XLEN = XLEN_DEF
) (
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   input  logic [2:0]      funct3_i,
   output logic            take_o,
   output logic            illegal_o
);

   // Decode funct3 into the condition result; 010/011 are reserved.
   always_comb begin
      take_o    = 1'b0;
      illegal_o = 1'b0;
      unique case (funct3_i)
         F3_BEQ:  take_o = (a_i == b_i);
         F3_BNE:  take_o = (a_i != b_i);
         F3_BLT:  take_o = ($signed(a_i) <  $signed(b_i));
         F3_BGE:  take_o = ($signed(a_i) >= $signed(b_i));
         F3_BLTU: take_o = (a_i <  b_i);
         F3_BGEU: take_o = (a_i >= b_i);
         default: illegal_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/ex_branch_redirect.sv
// EX-stage branch/jump resolver and EX/MEM control register. Resolves the
// ID/EX slot, drives the one-cycle PC redirect back to IF, holds Flush for
// FLUSH_CYCLES cycles while wrong-path slots drain, and registers link/RegWrite.
module ex_branch_redirect
   import ex_branch_redirect_pkg::*;
#(
   parameter int unsigned XLEN         = XLEN_DEF,
   parameter int unsigned FLUSH_CYCLES = 2
) (
   input logic                CLK,
   input logic                RST,
   ex_branch_redirect_if.slave bus
);

   localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);

   state_e          state_q;
   logic [1:0]      cnt_q;
   logic            pcsel_q;
   logic [XLEN-1:0] jb_q;
   logic            flush_q;
   logic            exvalid_q;
   logic            exrw_q;
   logic [XLEN-1:0] exlink_q;
   logic            mis_q;
   logic            ill_q;

   br_type_e        br_type_d;
   logic            cmp_take_d;
   logic            cmp_ill_d;
   logic [XLEN-1:0] pc_tgt_d;
   logic [XLEN-1:0] reg_sum_d;
   logic [XLEN-1:0] target_d;
   logic            taken_d;
   logic            misalign_d;
   logic            redirect_d;
   logic            illegal_d;
   logic [XLEN-1:0] link_d;

   branch_compare #(.XLEN(XLEN)) u_cmp (
      .a_i       (bus.rs1_value),
      .b_i       (bus.rs2_value),
      .funct3_i  (bus.Funct3),
      .take_o    (cmp_take_d),
      .illegal_o (cmp_ill_d)
   );

   // Target adders and taken/misalign decision for the current ID/EX slot.
   always_comb begin
      br_type_d  = br_type_e'(bus.BrType);
      pc_tgt_d   = bus.InPC + bus.Imm;
      reg_sum_d  = bus.rs1_value + bus.Imm;
      target_d   = (br_type_d == BR_JALR)
                   ? (reg_sum_d & ~{{(XLEN-1){1'b0}}, 1'b1})
                   : pc_tgt_d;
      taken_d    = (br_type_d == BR_JAL) || (br_type_d == BR_JALR) ||
                   ((br_type_d == BR_COND) && cmp_take_d);
      misalign_d = taken_d && (target_d[1:0] != 2'b00);
      redirect_d = taken_d && !misalign_d;
      illegal_d  = (br_type_d == BR_COND) && cmp_ill_d;
      link_d     = bus.InPC + XLEN'(4);
   end

   // RUN/SHADOW FSM with flush counter and all registered outputs; Stall freezes everything.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= ST_RUN;
         cnt_q     <= '0;
         pcsel_q   <= 1'b0;
         jb_q      <= '0;
         flush_q   <= 1'b0;
         exvalid_q <= 1'b0;
         exrw_q    <= 1'b0;
         exlink_q  <= '0;
         mis_q     <= 1'b0;
         ill_q     <= 1'b0;
      end else if (!bus.Stall) begin
         unique case (state_q)
            ST_RUN: begin
               pcsel_q   <= 1'b0;
               flush_q   <= 1'b0;
               mis_q     <= 1'b0;
               ill_q     <= 1'b0;
               exvalid_q <= bus.InValid;
               exrw_q    <= 1'b0;
               if (bus.InValid) begin
                  exlink_q <= link_d;
                  exrw_q   <= bus.InRegWrite && !misalign_d;
                  mis_q    <= misalign_d;
                  ill_q    <= illegal_d;
                  if (redirect_d) begin
                     pcsel_q <= 1'b1;
                     jb_q    <= target_d;
                     flush_q <= 1'b1;
                     cnt_q   <= FLUSH_LOAD;
                     state_q <= ST_SHADOW;
                  end
               end
            end
            ST_SHADOW: begin
               // Wrong-path slots are dropped without being resolved.
               pcsel_q   <= 1'b0;
               exvalid_q <= 1'b0;
               exrw_q    <= 1'b0;
               mis_q     <= 1'b0;
               ill_q     <= 1'b0;
               if (cnt_q == 2'd0) begin
                  flush_q <= 1'b0;
                  state_q <= ST_RUN;
               end else begin
                  cnt_q <= cnt_q - 2'd1;
               end
            end
            default: state_q <= ST_RUN;
         endcase
      end
   end

   assign bus.PCsel        = pcsel_q;
   assign bus.JumporBranch = jb_q;
   assign bus.Flush        = flush_q;
   assign bus.ExValid      = exvalid_q;
   assign bus.ExRegWrite   = exrw_q;
   assign bus.ExLink       = exlink_q;
   assign bus.MisalignErr  = mis_q;
   assign bus.IllegalBr    = ill_q;

endmodule

// File: tb/tb_ex_branch_redirect.sv
// Directed bench for ex_branch_redirect: a vector table of single-slot cases
// plus hand sequences for flush/squash, stall hold and reset mid-shadow.
module tb_ex_branch_redirect;

   logic CLK = 1'b0;
   logic RST;

   always #5 CLK = ~CLK;

   ex_branch_redirect_if #(.XLEN(32)) bus ();

   ex_branch_redirect #(.XLEN(32), .FLUSH_CYCLES(2)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   typedef struct {
      logic [1:0]  br;
      logic [2:0]  f3;
      logic [31:0] pc;
      logic [31:0] rs1;
      logic [31:0] rs2;
      logic [31:0] imm;
      logic        rw;
      logic        valid;
      logic        e_pcsel;
      logic [31:0] e_jb;
      logic        e_flush;
      logic        e_valid;
      logic        e_rw;
      logic [31:0] e_link;
      logic        e_mis;
      logic        e_ill;
   } vec_t;

   int checks = 0;
   int errors = 0;
   vec_t vecs[16];

   function automatic vec_t mk(
      input logic [1:0] br, input logic [2:0] f3, input logic [31:0] pc,
      input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
      input logic rw, input logic valid,
      input logic e_pcsel, input logic [31:0] e_jb, input logic e_flush,
      input logic e_valid, input logic e_rw, input logic [31:0] e_link,
      input logic e_mis, input logic e_ill);
      vec_t v;
      v.br = br; v.f3 = f3; v.pc = pc; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm;
      v.rw = rw; v.valid = valid;
      v.e_pcsel = e_pcsel; v.e_jb = e_jb; v.e_flush = e_flush; v.e_valid = e_valid;
      v.e_rw = e_rw; v.e_link = e_link; v.e_mis = e_mis; v.e_ill = e_ill;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic drive(input logic [1:0] br, input logic [2:0] f3, input logic [31:0] pc,
                        input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                        input logic rw, input logic valid);
      bus.BrType = br; bus.Funct3 = f3; bus.InPC = pc;
      bus.rs1_value = rs1; bus.rs2_value = rs2; bus.Imm = imm;
      bus.InRegWrite = rw; bus.InValid = valid;
   endtask

   task automatic chk_all(input string tag, input logic pcsel, input logic [31:0] jb,
                          input logic flush, input logic v, input logic rw,
                          input logic [31:0] link, input logic mis, input logic ill);
      chk({tag, ".PCsel"},        32'(bus.PCsel),       32'(pcsel));
      chk({tag, ".JumporBranch"}, bus.JumporBranch,     jb);
      chk({tag, ".Flush"},        32'(bus.Flush),       32'(flush));
      chk({tag, ".ExValid"},      32'(bus.ExValid),     32'(v));
      chk({tag, ".ExRegWrite"},   32'(bus.ExRegWrite),  32'(rw));
      chk({tag, ".ExLink"},       bus.ExLink,           link);
      chk({tag, ".MisalignErr"},  32'(bus.MisalignErr), 32'(mis));
      chk({tag, ".IllegalBr"},    32'(bus.IllegalBr),   32'(ill));
   endtask

   task automatic idle(input int unsigned n);
      bus.InValid = 1'b0;
      for (int unsigned k = 0; k < n; k++) step();
   endtask

   initial begin
      //            br     f3      pc           rs1          rs2          imm          rw valid  pcsel jb           fl v  rw link         mis ill
      vecs[0]  = mk(2'b01, 3'b000, 32'h100,     32'd5,       32'd5,       32'h20,      0, 1,     1, 32'h120,      1, 1, 0, 32'h104,     0, 0);
      vecs[1]  = mk(2'b01, 3'b001, 32'h200,     32'd5,       32'd5,       32'h40,      0, 1,     0, 32'h120,      0, 1, 0, 32'h204,     0, 0);
      vecs[2]  = mk(2'b01, 3'b100, 32'h300,     32'hFFFFFFFF,32'd1,       32'hFFFFFFF0,0, 1,     1, 32'h2F0,      1, 1, 0, 32'h304,     0, 0);
      vecs[3]  = mk(2'b01, 3'b110, 32'h300,     32'hFFFFFFFF,32'd1,       32'h10,      0, 1,     0, 32'h2F0,      0, 1, 0, 32'h304,     0, 0);
      vecs[4]  = mk(2'b01, 3'b101, 32'h400,     32'd1,       32'hFFFFFFFF,32'h8,       0, 1,     1, 32'h408,      1, 1, 0, 32'h404,     0, 0);
      vecs[5]  = mk(2'b01, 3'b111, 32'h400,     32'd1,       32'hFFFFFFFF,32'h8,       0, 1,     0, 32'h408,      0, 1, 0, 32'h404,     0, 0);
      vecs[6]  = mk(2'b01, 3'b100, 32'h500,     32'd3,       32'd3,       32'h100,     0, 1,     0, 32'h408,      0, 1, 0, 32'h504,     0, 0);
      vecs[7]  = mk(2'b01, 3'b101, 32'h500,     32'd3,       32'd3,       32'h100,     0, 1,     1, 32'h600,      1, 1, 0, 32'h504,     0, 0);
      vecs[8]  = mk(2'b01, 3'b010, 32'h600,     32'd7,       32'd7,       32'h8,       0, 1,     0, 32'h600,      0, 1, 0, 32'h604,     0, 1);
      vecs[9]  = mk(2'b11, 3'b000, 32'h700,     32'h203,     32'd0,       32'h0,       1, 1,     0, 32'h600,      0, 1, 0, 32'h704,     1, 0);
      vecs[10] = mk(2'b11, 3'b000, 32'h800,     32'h1001,    32'd0,       32'h10,      1, 1,     1, 32'h1010,     1, 1, 1, 32'h804,     0, 0);
      vecs[11] = mk(2'b00, 3'b011, 32'h900,     32'd9,       32'd4,       32'h7,       1, 1,     0, 32'h1010,     0, 1, 1, 32'h904,     0, 0);
      vecs[12] = mk(2'b10, 3'b000, 32'hFFFFFFF0,32'd0,       32'd0,       32'h20,      1, 1,     1, 32'h10,       1, 1, 1, 32'hFFFFFFF4,0, 0);
      vecs[13] = mk(2'b01, 3'b000, 32'h100,     32'd0,       32'd0,       32'h2,       1, 1,     0, 32'h10,       0, 1, 0, 32'h104,     1, 0);
      vecs[14] = mk(2'b10, 3'b000, 32'hA00,     32'd0,       32'd0,       32'h10,      1, 0,     0, 32'h10,       0, 0, 0, 32'h104,     0, 0);
      vecs[15] = mk(2'b01, 3'b111, 32'hB00,     32'hFFFFFFFF,32'd1,       32'hC,       0, 1,     1, 32'hB0C,      1, 1, 0, 32'hB04,     0, 0);

      RST = 1'b1;
      bus.Stall = 1'b0;
      drive(2'b00, 3'b000, '0, '0, '0, '0, 1'b0, 1'b0);
      step();
      step();
      chk_all("reset", 0, 32'h0, 0, 0, 0, 32'h0, 0, 0);
      RST = 1'b0;

      // Table: each slot resolved from RUN, then drained back to RUN.
      for (int i = 0; i < 16; i++) begin
         drive(vecs[i].br, vecs[i].f3, vecs[i].pc, vecs[i].rs1, vecs[i].rs2,
               vecs[i].imm, vecs[i].rw, vecs[i].valid);
         step();
         chk_all($sformatf("vec%0d", i), vecs[i].e_pcsel, vecs[i].e_jb, vecs[i].e_flush,
                 vecs[i].e_valid, vecs[i].e_rw, vecs[i].e_link, vecs[i].e_mis, vecs[i].e_ill);
         idle(3);
      end

      // jal then two wrong-path ALU ops squashed, third accepted.
      drive(2'b10, 3'b000, 32'h40, 32'd0, 32'd0, 32'h10, 1'b1, 1'b1);
      step();
      chk_all("jal", 1, 32'h50, 1, 1, 1, 32'h44, 0, 0);
      drive(2'b00, 3'b000, 32'h44, 32'd0, 32'd0, 32'h0, 1'b1, 1'b1);
      step();
      chk_all("sq1", 0, 32'h50, 1, 0, 0, 32'h44, 0, 0);
      drive(2'b00, 3'b000, 32'h48, 32'd0, 32'd0, 32'h0, 1'b1, 1'b1);
      step();
      chk_all("sq2", 0, 32'h50, 0, 0, 0, 32'h44, 0, 0);
      drive(2'b00, 3'b000, 32'h4C, 32'd0, 32'd0, 32'h0, 1'b1, 1'b1);
      step();
      chk_all("op3", 0, 32'h50, 0, 1, 1, 32'h50, 0, 0);
      idle(1);

      // Taken branch, then 3 stalled cycles hold everything.
      drive(2'b01, 3'b000, 32'h100, 32'd5, 32'd5, 32'h20, 1'b0, 1'b1);
      step();
      chk_all("stbr", 1, 32'h120, 1, 1, 0, 32'h104, 0, 0);
      bus.Stall = 1'b1;
      drive(2'b00, 3'b000, 32'h300, 32'd0, 32'd0, 32'h0, 1'b1, 1'b1);
      for (int s = 0; s < 3; s++) begin
         step();
         chk_all($sformatf("stall%0d", s), 1, 32'h120, 1, 1, 0, 32'h104, 0, 0);
      end
      bus.Stall = 1'b0;
      step();
      chk_all("unst1", 0, 32'h120, 1, 0, 0, 32'h104, 0, 0);
      step();
      chk_all("unst2", 0, 32'h120, 0, 0, 0, 32'h104, 0, 0);
      idle(1);
      chk_all("unst3", 0, 32'h120, 0, 0, 0, 32'h104, 0, 0);

      // Reset in the first SHADOW cycle, then a normal branch.
      drive(2'b10, 3'b000, 32'h1000, 32'd0, 32'd0, 32'h100, 1'b1, 1'b1);
      step();
      chk_all("rjal", 1, 32'h1100, 1, 1, 1, 32'h1004, 0, 0);
      RST = 1'b1;
      step();
      chk_all("rst2", 0, 32'h0, 0, 0, 0, 32'h0, 0, 0);
      RST = 1'b0;
      drive(2'b01, 3'b001, 32'h80, 32'd1, 32'd2, 32'h8, 1'b0, 1'b1);
      step();
      chk_all("postrst", 1, 32'h88, 1, 1, 0, 32'h84, 0, 0);
      idle(3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
